// File: rtl/ti_share_encoder.sv
// ti_share_encoder: splits an unmasked nibble into two Boolean shares
// {x ^ r, r} using one fresh random nibble per encode, with valid/ready
// handshakes on the data, randomness and share ports.
// Optional build macro: ZERO_RND_REJECT_EN (discard all-zero random words
// and count them on rnd_reject).
module ti_share_encoder #(
   parameter int unsigned NIB_W       = 4,
   parameter int unsigned RND_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [NIB_W-1:0]     s_data,
   input  logic                 rnd_valid,
   output logic                 rnd_ready,
   input  logic [NIB_W-1:0]     rnd_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [2*NIB_W-1:0]   m_data,
   output logic                 rnd_starve,
   output logic [CNT_W-1:0]     enc_count
`ifdef ZERO_RND_REJECT_EN
   ,
   output logic [7:0]           rnd_reject
`endif
);

   localparam int unsigned SHARE_W  = 2 * NIB_W;
   localparam int unsigned STARVE_W = 8;
   localparam int unsigned REJ_W    = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RND = 2'd1,
      OUT      = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [NIB_W-1:0]     x_reg;
   logic [NIB_W-1:0]     x_nxt;
   logic [SHARE_W-1:0]   m_data_nxt;
   logic [STARVE_W-1:0]  starve_cnt;
   logic [STARVE_W-1:0]  starve_cnt_nxt;
   logic                 rnd_starve_nxt;
   logic [CNT_W-1:0]     enc_count_nxt;
   logic                 rnd_take;
   logic                 rnd_use;
   logic                 rnd_zero;
   logic [REJ_W-1:0]     reject_cnt;
   logic [REJ_W-1:0]     reject_cnt_nxt;

   // Random word is all-zero (only acted upon when zero rejection is built in)
   assign rnd_zero = (rnd_data == '0);

   // A random word is consumed whenever it is offered in WAIT_RND
   assign rnd_take = (state == WAIT_RND) && rnd_valid;

`ifdef ZERO_RND_REJECT_EN
   // Zero words are consumed but must not mask the plaintext
   assign rnd_use = rnd_take && !rnd_zero;
`else
   assign rnd_use = rnd_take;
`endif

   // Next-state and next-register-value logic
   always_comb begin
      state_nxt      = state;
      x_nxt          = x_reg;
      m_data_nxt     = m_data;
      starve_cnt_nxt = starve_cnt;
      rnd_starve_nxt = rnd_starve;
      enc_count_nxt  = enc_count;
      reject_cnt_nxt = reject_cnt;

      case (state)
         IDLE: begin
            if (s_valid) begin
               x_nxt     = s_data;
               state_nxt = WAIT_RND;
            end
         end
         WAIT_RND: begin
            if (rnd_use) begin
               m_data_nxt = {x_reg ^ rnd_data, rnd_data};
               x_nxt      = '0;
               state_nxt  = OUT;
            end else begin
               if (starve_cnt != '1) begin
                  starve_cnt_nxt = starve_cnt + STARVE_W'(1);
               end
               if (rnd_take && rnd_zero && (reject_cnt != '1)) begin
                  reject_cnt_nxt = reject_cnt + REJ_W'(1);
               end
            end
         end
         OUT: begin
            if (m_ready) begin
               enc_count_nxt = enc_count + CNT_W'(1);
               state_nxt     = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (state_nxt != WAIT_RND) begin
         starve_cnt_nxt = '0;
      end
      if (starve_cnt_nxt >= STARVE_W'(RND_TIMEOUT)) begin
         rnd_starve_nxt = 1'b1;
      end
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         x_reg      <= '0;
         m_data     <= '0;
         starve_cnt <= '0;
         rnd_starve <= 1'b0;
         enc_count  <= '0;
         reject_cnt <= '0;
         s_ready    <= 1'b1;
         rnd_ready  <= 1'b0;
         m_valid    <= 1'b0;
      end else begin
         state      <= state_nxt;
         x_reg      <= x_nxt;
         m_data     <= m_data_nxt;
         starve_cnt <= starve_cnt_nxt;
         rnd_starve <= rnd_starve_nxt;
         enc_count  <= enc_count_nxt;
         reject_cnt <= reject_cnt_nxt;
         s_ready    <= (state_nxt == IDLE);
         rnd_ready  <= (state_nxt == WAIT_RND);
         m_valid    <= (state_nxt == OUT);
      end
   end

`ifdef ZERO_RND_REJECT_EN
   assign rnd_reject = reject_cnt;
`endif

   // Share vector must hold steady while back-pressured
   a_out_hold: assert property (@(posedge clk) disable iff (rst)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

   // Randomness is only requested while waiting for it
   a_rnd_state: assert property (@(posedge clk) disable iff (rst)
      rnd_ready |-> (state == WAIT_RND));

   // At most one handshake port is open at a time
   a_one_ready: assert property (@(posedge clk) disable iff (rst)
      $onehot0({s_ready, rnd_ready, m_valid}));

endmodule

// File: tb/tb_ti_share_encoder.sv
// Self-checking bench for ti_share_encoder: directed cases plus a randomised
// run, checked by a scoreboard fed from the input handshakes.
module tb_ti_share_encoder;

   localparam int unsigned NIB_W = 4;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned N_RAND = 1000;
`ifdef ZERO_RND_REJECT_EN
   localparam bit REJECT_ZERO = 1'b1;
`else
   localparam bit REJECT_ZERO = 1'b0;
`endif

   logic                 clk;
   logic                 rst;
   logic                 s_valid;
   logic                 s_ready;
   logic [NIB_W-1:0]     s_data;
   logic                 rnd_valid;
   logic                 rnd_ready;
   logic [NIB_W-1:0]     rnd_data;
   logic                 m_valid;
   logic                 m_ready;
   logic [2*NIB_W-1:0]   m_data;
   logic                 rnd_starve;
   logic [CNT_W-1:0]     enc_count;
`ifdef ZERO_RND_REJECT_EN
   logic [7:0]           rnd_reject;
`endif

   typedef struct {
      logic [NIB_W-1:0] x;
      logic [NIB_W-1:0] r;
   } exp_t;

   logic [NIB_W-1:0] pend_q[$];
   exp_t             exp_q[$];
   int               checks = 0;
   int               errors = 0;
   int               n_out  = 0;

   ti_share_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .rnd_valid  (rnd_valid),
      .rnd_ready  (rnd_ready),
      .rnd_data   (rnd_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .rnd_starve (rnd_starve),
      .enc_count  (enc_count)
`ifdef ZERO_RND_REJECT_EN
      ,
      .rnd_reject (rnd_reject)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: handshakes are judged at the falling edge, one half cycle
   // before the rising edge that completes them
   always @(negedge clk) begin
      if (rst) begin
         pend_q.delete();
         exp_q.delete();
         n_out = 0;
      end else begin
         if (s_valid && s_ready) begin
            pend_q.push_back(s_data);
         end
         if (rnd_valid && rnd_ready && !(REJECT_ZERO && rnd_data == '0)) begin
            if (pend_q.size() == 0) begin
               check("sb_rnd_no_pending", 32'(rnd_data), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e.x = pend_q.pop_front();
               e.r = rnd_data;
               exp_q.push_back(e);
            end
         end
         if (m_valid && m_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               check("sb_out_unexpected", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_m_data", 32'(m_data), 32'({e.x ^ e.r, e.r}));
               check("sb_share_xor", 32'(m_data[NIB_W-1:0] ^ m_data[2*NIB_W-1:NIB_W]), 32'(e.x));
               check("sb_share_a", 32'(m_data[NIB_W-1:0]), 32'(e.r));
            end
         end
      end
   end

   task automatic idle_inputs();
      s_valid   = 1'b0;
      s_data    = '0;
      rnd_valid = 1'b0;
      rnd_data  = '0;
      m_ready   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      idle_inputs();
      step(2);

      // Reset state
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_rnd_ready", 32'(rnd_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_starve", 32'(rnd_starve), 32'd0);
      check("rst_enc_count", 32'(enc_count), 32'd0);
      rst = 1'b0;
      step(1);

      // Basic encode: 0xA masked with 0x3
      s_valid = 1'b1; s_data = 4'hA; rnd_valid = 1'b1; rnd_data = 4'h3; m_ready = 1'b1;
      step(1);
      s_valid = 1'b0;
      check("basic_wait_m_valid", 32'(m_valid), 32'd0);
      check("basic_wait_rnd_ready", 32'(rnd_ready), 32'd1);
      step(1);
      check("basic_m_valid", 32'(m_valid), 32'd1);
      check("basic_m_data", 32'(m_data), 32'h93);
      rnd_valid = 1'b0;
      step(1);
      check("basic_enc_count", 32'(enc_count), 32'd1);
      check("basic_m_valid_drop", 32'(m_valid), 32'd0);

      // Output backpressure with inputs still offered
      s_valid = 1'b1; s_data = 4'hC; rnd_valid = 1'b1; rnd_data = 4'h5; m_ready = 1'b0;
      step(2);
      rnd_data = 4'h7;
      for (int i = 0; i < 5; i++) begin
         check("bp_m_valid", 32'(m_valid), 32'd1);
         check("bp_m_data", 32'(m_data), 32'h95);
         check("bp_s_ready", 32'(s_ready), 32'd0);
         check("bp_rnd_ready", 32'(rnd_ready), 32'd0);
         step(1);
      end
      s_valid = 1'b0; rnd_valid = 1'b0; m_ready = 1'b1;
      step(1);
      check("bp_enc_count", 32'(enc_count), 32'd2);
      check("bp_m_valid_drop", 32'(m_valid), 32'd0);
      m_ready = 1'b0;

      // Starvation: 0x5 accepted, no randomness for 20 cycles
      s_valid = 1'b1; s_data = 4'h5;
      step(1);
      s_valid = 1'b0;
      step(13);
      check("starve_early", 32'(rnd_starve), 32'd0);
      step(7);
      check("starve_set", 32'(rnd_starve), 32'd1);
      check("starve_no_out", 32'(m_valid), 32'd0);
      check("starve_still_wait", 32'(rnd_ready), 32'd1);
      rnd_valid = 1'b1; rnd_data = 4'hF;
      step(1);
      rnd_valid = 1'b0;
      check("starve_m_data", 32'(m_data), 32'hAF);
      check("starve_sticky_out", 32'(rnd_starve), 32'd1);
      m_ready = 1'b1;
      step(1);
      m_ready = 1'b0;
      step(2);
      check("starve_sticky_idle", 32'(rnd_starve), 32'd1);
      check("starve_enc_count", 32'(enc_count), 32'd3);

      // Reset in WAIT_RND
      s_valid = 1'b1; s_data = 4'h3;
      step(1);
      s_valid = 1'b0;
      rst = 1'b1;
      step(1);
      check("rst_wait_m_valid", 32'(m_valid), 32'd0);
      check("rst_wait_m_data", 32'(m_data), 32'd0);
      check("rst_wait_s_ready", 32'(s_ready), 32'd1);
      check("rst_wait_enc_count", 32'(enc_count), 32'd0);
      check("rst_wait_starve", 32'(rnd_starve), 32'd0);
      rst = 1'b0;

      // Reset in OUT
      s_valid = 1'b1; s_data = 4'h9;
      step(1);
      s_valid = 1'b0; rnd_valid = 1'b1; rnd_data = 4'h6;
      step(1);
      rnd_valid = 1'b0;
      check("pre_rst_out_m_valid", 32'(m_valid), 32'd1);
      rst = 1'b1;
      step(1);
      check("rst_out_m_valid", 32'(m_valid), 32'd0);
      check("rst_out_m_data", 32'(m_data), 32'd0);
      check("rst_out_s_ready", 32'(s_ready), 32'd1);
      check("rst_out_enc_count", 32'(enc_count), 32'd0);
      rst = 1'b0;
      step(1);

`ifdef ZERO_RND_REJECT_EN
      // Zero random word is consumed and discarded
      do_reset();
      s_valid = 1'b1; s_data = 4'h6;
      step(1);
      s_valid = 1'b0; rnd_valid = 1'b1; rnd_data = 4'h0;
      step(1);
      check("rej_no_out", 32'(m_valid), 32'd0);
      check("rej_count", 32'(rnd_reject), 32'd1);
      rnd_data = 4'h1;
      step(1);
      rnd_valid = 1'b0;
      check("rej_m_data", 32'(m_data), 32'h71);
      m_ready = 1'b1;
      step(1);
      m_ready = 1'b0;
`endif

      // Randomised encodes with random valid/ready gaps
      do_reset();
      cyc = 0;
      while (n_out < int'(N_RAND) && cyc < 20000) begin
         s_valid   = ($urandom_range(3) != 0);
         s_data    = NIB_W'($urandom_range(15));
         rnd_valid = ($urandom_range(3) != 0);
         rnd_data  = NIB_W'($urandom_range(15));
         m_ready   = ($urandom_range(3) != 0);
         step(1);
         cyc++;
      end
      idle_inputs();
      step(1);
      check("rand_done", 32'(n_out), 32'(N_RAND));
      check("rand_enc_count", 32'(enc_count), 32'(N_RAND));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ti_share_encoder.md
Name: ti_share_encoder

Overview:
- Masking front end for the 4-bit TI S-box datapath.
- Takes an unmasked nibble and one fresh random nibble per encode, and emits a 2-share 8-bit vector. Bits [3:0] are share A, bits [7:4] are share B.
- The 8-bit vector feeds the per-coordinate TI share functions directly.
- Registered output, with valid/ready handshakes on the data input, the randomness input and the share output.

Parameters:
- NIB_W, 4: nibble width. Share vector width is 2*NIB_W.
- RND_TIMEOUT, 15: WAIT_RND cycles without randomness before rnd_starve sets. Range 1..255.
- CNT_W, 16: width of enc_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  unmasked nibble valid.
- s_ready  out  1  encoder can accept a nibble.
- s_data  in  NIB_W  unmasked nibble.
- rnd_valid  in  1  random nibble valid.
- rnd_ready  out  1  encoder consumes the random nibble this cycle.
- rnd_data  in  NIB_W  random nibble.
- m_valid  out  1  share vector valid.
- m_ready  in  1  downstream accepts the share vector.
- m_data  out  2*NIB_W  {share B, share A}.
- rnd_starve  out  1  sticky randomness-starvation flag.
- enc_count  out  CNT_W  number of completed output handshakes.

Behaviour:
- Reset: synchronous and active-high. On reset:
  - FSM goes to IDLE.
  - s_ready=1, rnd_ready=0, m_valid=0.
  - m_data=0, rnd_starve=0, enc_count=0.
  - The starvation counter and the internal nibble register clear.
- Reset mid-operation aborts any held nibble. No partial share vector is ever presented.
- FSM states: IDLE, WAIT_RND, OUT.
- IDLE:
  - s_ready=1.
  - On s_valid, s_data is latched into x_reg and the FSM moves to WAIT_RND.
  - rnd_ready=0.
- WAIT_RND:
  - s_ready=0, rnd_ready=1.
  - On rnd_valid, the random nibble r=rnd_data is consumed. Next cycle:
    - m_data[3:0]=r.
    - m_data[7:4]=x_reg^r.
    - m_valid=1.
    - FSM moves to OUT.
  - Each cycle in WAIT_RND without rnd_valid increments the starvation counter (saturating).
  - When the counter reaches RND_TIMEOUT, rnd_starve sets and stays set until reset.
  - The FSM keeps waiting. It never emits unmasked or stale-masked data.
  - The counter clears on leaving WAIT_RND.
- OUT:
  - m_valid=1. m_data is stable until the handshake completes.
  - s_ready=0, rnd_ready=0.
  - On m_ready:
    - enc_count increments and wraps at 2^CNT_W.
    - m_valid drops next cycle.
    - FSM returns to IDLE.
- Latency and throughput:
  - Input accept to m_valid is 2 cycles minimum (rnd_valid present on the first WAIT_RND cycle).
  - One encode per 3 cycles at best.
- Randomness rules:
  - Each random nibble is used for exactly one encode and never reused.
  - rnd_ready is asserted only in WAIT_RND.
- Share invariants:
  - m_data[3:0]^m_data[7:4] equals the accepted nibble.
  - The unmasked x_reg value never appears on any output.
- Simultaneous events:
  - s_valid in OUT is ignored, because s_ready=0.
  - rnd_valid in IDLE or OUT is ignored. No random nibble is consumed.
  - m_ready while m_valid=0 has no effect.

Optional Feature:
- Macro: ZERO_RND_REJECT_EN.
- Defined:
  - In WAIT_RND, rnd_data==0 is still consumed (rnd_ready=1) but discarded.
  - The FSM stays in WAIT_RND and the starvation counter keeps counting.
  - This prevents share B from equalling the plaintext.
  - An extra output rnd_reject [7:0] counts rejected random words. It saturates at 255 and resets to 0.
- Undefined:
  - Any rnd_data value, including 0, is used.
  - The rnd_reject port is absent.

Test Plan:
- Basic encode: rst 1 cycle; s_data=0xA, rnd_data=0x3 (rnd_valid held), m_ready=1 -> m_valid two cycles after s accept; m_data=0x93; enc_count=1.
- Output backpressure: m_ready=0 for 5 cycles with s_valid and rnd_valid held -> m_data held constant; s_ready=0; rnd_ready=0; no random consumed; handshake completes on m_ready=1.
- Starvation: rnd_valid=0 for 20 cycles after accepting 0x5 with RND_TIMEOUT=15 -> rnd_starve=1 from the 15th WAIT_RND cycle. Then rnd_data=0xF -> m_data=0xAF; rnd_starve stays 1 until rst.
- Reset mid-operation: rst asserted in WAIT_RND and in OUT -> next cycle m_valid=0, m_data=0, s_ready=1, enc_count=0.
- Randomised 1000 encodes: random s_data, rnd_data and valid/ready gaps -> every output satisfies m_data[3:0]^m_data[7:4]==accepted nibble; share A equals the consumed random; enc_count=1000.
- ZERO_RND_REJECT_EN defined: s_data=0x6, rnd_data=0x0 then 0x1 -> first random consumed and rejected, rnd_reject=1; m_data=0x71.
